// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the LSU-to-memory controller.
package mem_ctrl_pkg;

  localparam int unsigned DefNumConsumers = 4;
  localparam int unsigned DefAddrBits     = 8;
  localparam int unsigned DefDataBits     = 8;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StReadWait  = 2'b01,
    StWriteWait = 2'b10,
    StRelease   = 2'b11
  } mem_ctrl_state_e;

  // Width of a consumer index; never zero so single-consumer builds still elaborate.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first set request at or after ptr wins.
module rr_arbiter import mem_ctrl_pkg::*; #(
  parameter int unsigned NUM_REQ = DefNumConsumers,
  parameter int unsigned IdW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  output logic               grant_valid_o,
  output logic [IdW-1:0]     grant_id_o
);

  logic [IdW-1:0] cand;

  // Walk ptr, ptr+1, ... (mod NUM_REQ) and keep the first requester found.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_id_o    = '0;
    cand          = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdW'((32'(ptr_i) + k) % NUM_REQ);
      if (!grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_id_o    = cand;
      end
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Round-robin arbiter of per-thread LSU read/write requests onto a single
// data-memory port, one transaction in flight, ready held until valid drops.
module mem_controller import mem_ctrl_pkg::*; #(
  parameter int unsigned NUM_CONSUMERS = DefNumConsumers,
  parameter int unsigned ADDR_BITS     = DefAddrBits,
  parameter int unsigned DATA_BITS     = DefDataBits
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
);

  localparam int unsigned   IdW    = id_width(NUM_CONSUMERS);
  localparam logic [IdW-1:0] LastId = IdW'(NUM_CONSUMERS - 1);

  mem_ctrl_state_e        state_q;
  logic [IdW-1:0]         rr_ptr_q;
  logic [IdW-1:0]         cur_id_q;
  logic [DATA_BITS-1:0]   rd_data_q [NUM_CONSUMERS];

  logic [ADDR_BITS-1:0]   rd_addr [NUM_CONSUMERS];
  logic [ADDR_BITS-1:0]   wr_addr [NUM_CONSUMERS];
  logic [DATA_BITS-1:0]   wr_data [NUM_CONSUMERS];

  logic [NUM_CONSUMERS-1:0] req;
  logic                     grant_valid;
  logic [IdW-1:0]           grant_id;
  logic                     release_done;
  logic [IdW-1:0]           next_ptr;

  // Unpack the flattened per-consumer buses into indexable arrays.
  for (genvar g = 0; g < NUM_CONSUMERS; g++) begin : g_slice
    assign rd_addr[g] = consumer_read_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_addr[g] = consumer_write_address[g*ADDR_BITS +: ADDR_BITS];
    assign wr_data[g] = consumer_write_data[g*DATA_BITS +: DATA_BITS];
    assign consumer_read_data[g*DATA_BITS +: DATA_BITS] = rd_data_q[g];
  end

  assign req = consumer_read_valid | consumer_write_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_CONSUMERS),
    .IdW     (IdW)
  ) u_rr_arbiter (
    .req_i         (req),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  // The ready bit that is set tells which valid the LSU must drop to finish.
  assign release_done = consumer_read_ready[cur_id_q] ? !consumer_read_valid[cur_id_q]
                                                      : !consumer_write_valid[cur_id_q];
  assign next_ptr     = (cur_id_q == LastId) ? '0 : cur_id_q + 1'b1;

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q              <= StIdle;
      rr_ptr_q             <= '0;
      cur_id_q             <= '0;
      consumer_read_ready  <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      for (int i = 0; i < NUM_CONSUMERS; i++) begin
        rd_data_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            cur_id_q <= grant_id;
            // A consumer raising both valids is served read first.
            if (consumer_read_valid[grant_id]) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= rd_addr[grant_id];
              state_q          <= StReadWait;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= wr_addr[grant_id];
              mem_write_data    <= wr_data[grant_id];
              state_q           <= StWriteWait;
            end
          end
        end
        StReadWait: begin
          if (mem_read_ready) begin
            mem_read_valid                <= 1'b0;
            rd_data_q[cur_id_q]           <= mem_read_data;
            consumer_read_ready[cur_id_q] <= 1'b1;
            state_q                       <= StRelease;
          end
        end
        StWriteWait: begin
          if (mem_write_ready) begin
            mem_write_valid                <= 1'b0;
            consumer_write_ready[cur_id_q] <= 1'b1;
            state_q                        <= StRelease;
          end
        end
        StRelease: begin
          if (release_done) begin
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            rr_ptr_q             <= next_ptr;
            state_q              <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed and randomized checks of mem_controller against a queue-free
// round-robin reference model.
module tb_mem_controller;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    consumer_read_valid = '0;
  logic [N*AW-1:0] consumer_read_address = '0;
  logic [N-1:0]    consumer_read_ready;
  logic [N*DW-1:0] consumer_read_data;
  logic [N-1:0]    consumer_write_valid = '0;
  logic [N*AW-1:0] consumer_write_address = '0;
  logic [N*DW-1:0] consumer_write_data = '0;
  logic [N-1:0]    consumer_write_ready;
  logic            mem_read_valid;
  logic [AW-1:0]   mem_read_address;
  logic            mem_read_ready = 1'b0;
  logic [DW-1:0]   mem_read_data = '0;
  logic            mem_write_valid;
  logic [AW-1:0]   mem_write_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_write_ready = 1'b0;

  mem_controller #(
    .NUM_CONSUMERS (N),
    .ADDR_BITS     (AW),
    .DATA_BITS     (DW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: rotating pointer, last data returned per consumer, pending requests.
  int         model_ptr;
  logic [7:0] model_rdata [N];
  bit         pend_r [N];
  bit         pend_w [N];
  logic [7:0] ra [N];
  logic [7:0] wa [N];
  logic [7:0] wd [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [N*DW-1:0] model_rdata_vec();
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = model_rdata[i];
    return v;
  endfunction

  task automatic wait_grant(input string tag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (mem_read_valid || mem_write_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no memory request expected one within 16 cycles", tag);
    end
  endtask

  task automatic read_resp(input logic [7:0] d, input int lat);
    repeat (lat) tick();
    mem_read_data  = d;
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
  endtask

  task automatic write_resp(input int lat);
    repeat (lat) tick();
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
  endtask

  task automatic clear_inputs();
    consumer_read_valid  = '0;
    consumer_write_valid = '0;
    mem_read_ready       = 1'b0;
    mem_write_ready      = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_ptr = 0;
    for (int i = 0; i < N; i++) begin
      model_rdata[i] = '0;
      pend_r[i] = 1'b0;
      pend_w[i] = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    int         win;
    int         lat;
    logic [7:0] d;
    logic [3:0] pick;

    // Reset values, applied without any clock edge.
    #2 reset = 1'b0;
    #1;
    chk("rst_mem_read_valid", 32'(mem_read_valid), 0);
    chk("rst_mem_write_valid", 32'(mem_write_valid), 0);
    chk("rst_read_ready", 32'(consumer_read_ready), 0);
    chk("rst_write_ready", 32'(consumer_write_ready), 0);
    chk("rst_read_data", consumer_read_data, 0);
    chk("rst_mem_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
    tick();
    reset = 1'b1;

    // Single read: consumer 2, addr 1A, memory answers after 3 cycles.
    tick();
    consumer_read_address[2*AW +: AW] = 8'h1A;
    consumer_read_valid[2] = 1'b1;
    wait_grant("rd1_grant", ok);
    chk("rd1_mem_read_valid", 32'(mem_read_valid), 1);
    chk("rd1_mem_read_address", 32'(mem_read_address), 32'h1A);
    chk("rd1_no_write", 32'(mem_write_valid), 0);
    consumer_read_address[2*AW +: AW] = 8'hFF;
    repeat (3) tick();
    chk("rd1_ready_early", 32'(consumer_read_ready), 0);
    chk("rd1_addr_latched", 32'(mem_read_address), 32'h1A);
    read_resp(8'h5C, 0);
    chk("rd1_ready", 32'(consumer_read_ready), 32'b0100);
    chk("rd1_data", 32'(consumer_read_data[2*DW +: DW]), 32'h5C);
    chk("rd1_mem_read_drop", 32'(mem_read_valid), 0);
    tick();
    chk("rd1_ready_held", 32'(consumer_read_ready), 32'b0100);
    consumer_read_valid[2] = 1'b0;
    tick();
    chk("rd1_ready_clear", 32'(consumer_read_ready), 0);
    chk("rd1_data_hold", 32'(consumer_read_data[2*DW +: DW]), 32'h5C);

    // Stray read ready while idle does nothing.
    mem_read_ready = 1'b1;
    tick();
    mem_read_ready = 1'b0;
    tick();
    chk("stray_idle_ready", 32'(consumer_read_ready), 0);
    chk("stray_idle_mem", 32'({mem_read_valid, mem_write_valid}), 0);

    // Single write: consumer 0 writes AB to 30, with a wrong-kind ready first.
    consumer_write_address[0 +: AW] = 8'h30;
    consumer_write_data[0 +: DW]    = 8'hAB;
    consumer_write_valid[0]         = 1'b1;
    wait_grant("wr1_grant", ok);
    chk("wr1_mem_write_valid", 32'(mem_write_valid), 1);
    chk("wr1_addr", 32'(mem_write_address), 32'h30);
    chk("wr1_data", 32'(mem_write_data), 32'hAB);
    chk("wr1_no_read", 32'(mem_read_valid), 0);
    read_resp(8'h99, 0);
    chk("wr1_stray_ignored", 32'({mem_write_valid, consumer_write_ready, consumer_read_ready}),
        32'h100);
    write_resp(1);
    chk("wr1_ready", 32'(consumer_write_ready), 32'b0001);
    chk("wr1_no_read_ready", 32'(consumer_read_ready), 0);
    chk("wr1_data_untouched", 32'(consumer_read_data[2*DW +: DW]), 32'h5C);
    consumer_write_valid[0] = 1'b0;
    tick();
    chk("wr1_ready_clear", 32'(consumer_write_ready), 0);

    // Read-over-write on consumer 1.
    consumer_read_address[1*AW +: AW]  = 8'h10;
    consumer_write_address[1*AW +: AW] = 8'h11;
    consumer_write_data[1*DW +: DW]    = 8'h3C;
    consumer_read_valid[1]  = 1'b1;
    consumer_write_valid[1] = 1'b1;
    wait_grant("row_grant_rd", ok);
    chk("row_read_first", 32'({mem_read_valid, mem_write_valid}), 32'b10);
    chk("row_read_addr", 32'(mem_read_address), 32'h10);
    read_resp(8'h77, 2);
    chk("row_read_ready", 32'({consumer_read_ready, consumer_write_ready}), 32'h20);
    chk("row_no_write_in_release", 32'(mem_write_valid), 0);
    consumer_read_valid[1] = 1'b0;
    tick();
    chk("row_no_write_yet", 32'(mem_write_valid), 0);
    wait_grant("row_grant_wr", ok);
    chk("row_write_addr", 32'({mem_write_valid, mem_write_address, mem_write_data}),
        32'h1113C);
    write_resp(0);
    chk("row_write_ready", 32'(consumer_write_ready), 32'b0010);
    consumer_write_valid[1] = 1'b0;
    tick();

    // Abort: consumer 3 drops valid mid-read; pointer then wraps to 0.
    consumer_read_address[3*AW +: AW] = 8'h55;
    consumer_read_valid[3] = 1'b1;
    wait_grant("abort_grant", ok);
    chk("abort_addr", 32'(mem_read_address), 32'h55);
    consumer_read_valid[3] = 1'b0;
    tick();
    chk("abort_mem_still_valid", 32'(mem_read_valid), 1);
    read_resp(8'hE1, 0);
    chk("abort_ready_pulse", 32'(consumer_read_ready), 32'b1000);
    chk("abort_data", 32'(consumer_read_data[3*DW +: DW]), 32'hE1);
    tick();
    chk("abort_ready_gone", 32'(consumer_read_ready), 0);
    consumer_read_address[0 +: AW]    = 8'h60;
    consumer_read_address[2*AW +: AW] = 8'h62;
    consumer_read_address[3*AW +: AW] = 8'h63;
    consumer_read_valid = 4'b1101;
    wait_grant("wrap_grant", ok);
    chk("wrap_to_zero", 32'(mem_read_address), 32'h60);
    read_resp(8'h01, 0);
    consumer_read_valid = '0;
    tick();

    // Async reset during write wait; afterwards consumer 0 wins first.
    consumer_write_address[2*AW +: AW] = 8'h42;
    consumer_write_data[2*DW +: DW]    = 8'h24;
    consumer_write_valid[2] = 1'b1;
    wait_grant("arst_grant", ok);
    chk("arst_in_write", 32'(mem_write_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_write_valid", 32'(mem_write_valid), 0);
    chk("arst_mem_write_bus", 32'({mem_write_address, mem_write_data}), 0);
    chk("arst_readies", 32'({consumer_read_ready, consumer_write_ready}), 0);
    chk("arst_read_data", consumer_read_data, 0);
    tick();
    clear_inputs();
    reset = 1'b1;
    consumer_read_address[0 +: AW]    = 8'h70;
    consumer_read_address[2*AW +: AW] = 8'h72;
    consumer_read_valid = 4'b0101;
    wait_grant("arst_first_grant", ok);
    chk("arst_first_is_0", 32'(mem_read_address), 32'h70);
    read_resp(8'h11, 1);
    consumer_read_valid = '0;
    tick();

    // Fairness: all four read continuously, re-requesting right after release.
    do_reset();
    for (int i = 0; i < N; i++) consumer_read_address[i*AW +: AW] = 8'(8'h40 + i);
    consumer_read_valid = '1;
    for (int g = 0; g < 5; g++) begin
      wait_grant("fair_grant", ok);
      chk("fair_order", 32'(mem_read_address), 32'(8'h40 + (g % N)));
      read_resp(8'(g), 0);
      chk("fair_ready", 32'(consumer_read_ready), 32'(1 << (g % N)));
      consumer_read_valid[g % N] = 1'b0;
      tick();
      consumer_read_valid[g % N] = 1'b1;
    end
    consumer_read_valid = '0;
    tick();
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int r = 0; r < 30; r++) begin
      pick = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        if (pick[i]) begin
          int kind;
          kind = $urandom_range(0, 2);
          pend_r[i] = (kind != 1);
          pend_w[i] = (kind != 0);
          ra[i] = 8'($urandom);
          wa[i] = 8'($urandom);
          wd[i] = 8'($urandom);
          consumer_read_address[i*AW +: AW]  = ra[i];
          consumer_write_address[i*AW +: AW] = wa[i];
          consumer_write_data[i*DW +: DW]    = wd[i];
          consumer_read_valid[i]  = pend_r[i];
          consumer_write_valid[i] = pend_w[i];
        end
      end
      forever begin
        win = -1;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (model_ptr + k) % N;
          if (win < 0 && (pend_r[idx] || pend_w[idx])) win = idx;
        end
        if (win < 0) break;
        wait_grant("rnd_grant", ok);
        if (!ok) begin
          do_reset();
          break;
        end
        lat = $urandom_range(0, 3);
        if (pend_r[win]) begin
          chk("rnd_rd_kind", 32'({mem_read_valid, mem_write_valid}), 32'b10);
          chk("rnd_rd_addr", 32'(mem_read_address), 32'(ra[win]));
          d = 8'($urandom);
          read_resp(d, lat);
          model_rdata[win] = d;
          chk("rnd_rd_ready", 32'({consumer_read_ready, consumer_write_ready}),
              32'((1 << win) << N));
          chk("rnd_rd_data", consumer_read_data, model_rdata_vec());
          consumer_read_valid[win] = 1'b0;
          pend_r[win] = 1'b0;
        end else begin
          chk("rnd_wr_kind", 32'({mem_read_valid, mem_write_valid}), 32'b01);
          chk("rnd_wr_bus", 32'({mem_write_address, mem_write_data}), 32'({wa[win], wd[win]}));
          write_resp(lat);
          chk("rnd_wr_ready", 32'({consumer_read_ready, consumer_write_ready}), 32'(1 << win));
          consumer_write_valid[win] = 1'b0;
          pend_w[win] = 1'b0;
        end
        tick();
        chk("rnd_release", 32'({consumer_read_ready, consumer_write_ready}), 0);
        model_ptr = (win + 1) % N;
      end
    end
    clear_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Sits directly downstream of the per-thread load/store units.
- Arbitrates their read/write requests onto one shared data-memory port, round-robin, one transaction in flight at a time.
- Returns read data and completion (ready) to the requesting LSU.
- Holds ready until that LSU drops valid, matching the LSU's valid-held-until-ready protocol.

Parameters:
- NUM_CONSUMERS, 4, number of LSU request channels.
- ADDR_BITS, 8, memory address width.
- DATA_BITS, 8, memory data width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets).
- consumer_read_valid  input  NUM_CONSUMERS  per-LSU read request.
- consumer_read_address  input  NUM_CONSUMERS*ADDR_BITS  flattened; slice i = LSU i.
- consumer_read_ready  output  NUM_CONSUMERS  per-LSU read complete.
- consumer_read_data  output  NUM_CONSUMERS*DATA_BITS  flattened read data.
- consumer_write_valid  input  NUM_CONSUMERS  per-LSU write request.
- consumer_write_address  input  NUM_CONSUMERS*ADDR_BITS  flattened.
- consumer_write_data  input  NUM_CONSUMERS*DATA_BITS  flattened.
- consumer_write_ready  output  NUM_CONSUMERS  per-LSU write complete.
- mem_read_valid  output  1  read request to memory.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  memory read done; mem_read_data valid this cycle.
- mem_read_data  input  DATA_BITS  memory read data.
- mem_write_valid  output  1  write request to memory.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  memory write done.

Behaviour:
- Reset:
  - All outputs are registered and reset to 0.
  - state=IDLE, rr_ptr=0, cur_id=0.
- States: IDLE, READ_WAIT, WRITE_WAIT, RELEASE.
- IDLE:
  - Scan consumers rr_ptr, rr_ptr+1, ... (mod NUM_CONSUMERS). The first with read_valid or write_valid wins.
  - If a consumer has both asserted, the read wins.
  - Read grant: on that edge, mem_read_valid<=1, mem_read_address<=its address, cur_id<=i, go READ_WAIT.
  - Write grant: mem_write_valid<=1, mem_write_address/data<=its slices, cur_id<=i, go WRITE_WAIT.
  - No requests: stay in IDLE.
- READ_WAIT:
  - On mem_read_ready: mem_read_valid<=0, consumer_read_data[cur_id]<=mem_read_data, consumer_read_ready[cur_id]<=1, go RELEASE.
  - Address and data are latched at grant; later changes on the consumer inputs are ignored.
- WRITE_WAIT:
  - On mem_write_ready: mem_write_valid<=0, consumer_write_ready[cur_id]<=1, go RELEASE.
- RELEASE:
  - Wait until the granted consumer's corresponding valid is low.
  - Then clear its ready, rr_ptr<=(cur_id+1) mod NUM_CONSUMERS, go IDLE.
- Latency:
  - Request valid seen at edge E → mem_*_valid high after E.
  - Memory ready at edge M → consumer ready high after M.
  - Minimum from consumer valid to consumer ready is 2 edges if memory responds in the first cycle.
- Data hold: consumer_read_data slices persist until overwritten by a later read to the same consumer.
- Exclusivity: at most one mem_*_valid high; at most one consumer ready bit high.
- Abort: if the granted consumer drops valid during READ_WAIT/WRITE_WAIT, the memory transaction still completes.
  - Ready still pulses, then RELEASE exits on the next edge.
  - Memory never sees a dropped request.
- Stray ready: mem_read_ready or mem_write_ready arriving in IDLE/RELEASE, or of the wrong kind, is ignored.
- Reset mid-transaction: everything returns to reset values asynchronously, with no completion pulse.
- Wrap: rr_ptr = NUM_CONSUMERS-1 advances to 0.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - the 2-bit state encodings (IDLE=00, READ_WAIT=01, WRITE_WAIT=10, RELEASE=11);
  - the default width constants.
- One natural sub-module: rr_arbiter.
  - Combinational priority pick over a request vector, starting at rr_ptr.
  - Outputs grant_valid and grant_id.
  - Reusable for a future instruction-fetch controller.

Test Plan:
- Single read: consumer 2 reads addr 0x1A; memory returns 0x5C after 3 cycles → consumer_read_data[2]=0x5C, ready[2]=1 until valid[2] drops, then 0.
- Single write: consumer 0 writes 0xAB to 0x30 → mem_write_valid with addr 0x30 / data 0xAB; after mem_write_ready, write_ready[0] pulses; no read activity.
- Fairness: all 4 consumers request reads continuously → grant order 0,1,2,3,0; no consumer is granted twice before the others.
- Read-over-write: consumer 1 asserts read 0x10 and write 0x11 together → read issued first, write only after the read's RELEASE completes.
- Abort: consumer 3 drops valid during READ_WAIT → memory read still completes; ready[3] high one cycle; IDLE next; rr_ptr=0 (wrap).
- Async reset during WRITE_WAIT → all outputs 0 immediately without a clock edge; first grant after reset goes to consumer 0.
